// File: rtl/cov_pkg.sv
// Shared types and constants for the covariance sequencer and its accumulator bank.
// Optional build macro COV_ROUND_EN (used in cov_accum) selects round-half-up normalisation.
package cov_pkg;

  localparam int unsigned NUM_PAIRS = 10;

  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_LOG2N = 7;
  localparam int unsigned DEF_ACC_W = 24;

  // Upper-triangle lane indices, XaXb -> Pab
  localparam int unsigned P11 = 0;
  localparam int unsigned P12 = 1;
  localparam int unsigned P13 = 2;
  localparam int unsigned P14 = 3;
  localparam int unsigned P22 = 4;
  localparam int unsigned P23 = 5;
  localparam int unsigned P24 = 6;
  localparam int unsigned P33 = 7;
  localparam int unsigned P34 = 8;
  localparam int unsigned P44 = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } cov_state_e;

endpackage

// File: rtl/cov_accum.sv
// cov_accum: 10-lane signed accumulator bank with clear, accumulate and normalise.
// Build macro: COV_ROUND_EN selects round-half-up normalisation; default is floor.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         zero all accumulators (priority over acc_en)
//   acc_en      add sign-extended prod_in lanes into the accumulators
//   norm_en     load cov_out with the normalised accumulator values
//   prod_in     NUM_PAIRS packed DW-bit signed products
//   cov_out     NUM_PAIRS packed DW-bit normalised results, held between loads
module cov_accum
  import cov_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LOG2N = DEF_LOG2N,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic                    norm_en,
  input  logic [NUM_PAIRS*DW-1:0] prod_in,
  output logic [NUM_PAIRS*DW-1:0] cov_out
);

`ifdef COV_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (LOG2N - 1);
`endif

  logic signed [ACC_W-1:0]     acc_q [NUM_PAIRS];
  logic signed [ACC_W-1:0]     acc_d [NUM_PAIRS];
  logic [NUM_PAIRS*DW-1:0]     cov_q;
  logic [NUM_PAIRS*DW-1:0]     cov_d;

  // Accumulate and normalise; the width rule on ACC_W makes overflow impossible
  always_comb begin
    cov_d = cov_q;
    for (int i = 0; i < int'(NUM_PAIRS); i++) begin
      acc_d[i] = acc_q[i];
      if (clr) begin
        acc_d[i] = '0;
      end else if (acc_en) begin
        acc_d[i] = acc_q[i] + ACC_W'(signed'(prod_in[DW*i +: DW]));
      end
      if (norm_en) begin
`ifdef COV_ROUND_EN
        cov_d[DW*i +: DW] = DW'((acc_q[i] + ROUND_BIAS) >>> LOG2N);
`else
        cov_d[DW*i +: DW] = DW'(acc_q[i] >>> LOG2N);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_PAIRS); i++) begin
        acc_q[i] <= '0;
      end
      cov_q <= '0;
    end else begin
      acc_q <= acc_d;
      cov_q <= cov_d;
    end
  end

  assign cov_out = cov_q;

endmodule

// File: rtl/cov_seq_ctrl.sv
// cov_seq_ctrl: sequencer for the whitening-stage covariance datapath.
// Reads N_SAMPLES sample vectors, pipelines the read strobe into multiplier and
// accumulator enables, then normalises and presents the 4x4 covariance triangle.
// Build macro: COV_ROUND_EN (passed to cov_accum) selects rounding normalisation.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       frame request, honoured only in IDLE
//   src_rdy     sample buffer accepts a read this cycle
//   rd_en       read strobe (same-cycle qualified by src_rdy)
//   rd_addr     sample index being read
//   mult_en     multiplier enable, rd_en delayed by one cycle
//   prod_in     registered products, lane i at [DW*i +: DW]
//   cov_out     normalised covariance, same lane order
//   busy        high while not IDLE
//   done        one-cycle pulse when cov_out becomes valid
module cov_seq_ctrl
  import cov_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 128,
  parameter int unsigned LOG2N     = DEF_LOG2N,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned ACC_W     = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    src_rdy,
  output logic                    rd_en,
  output logic [LOG2N-1:0]        rd_addr,
  output logic                    mult_en,
  input  logic [NUM_PAIRS*DW-1:0] prod_in,
  output logic [NUM_PAIRS*DW-1:0] cov_out,
  output logic                    busy,
  output logic                    done
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_SAMPLES - 1);

  cov_state_e       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             mult_en_q;
  logic             acc_en_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_c;
  logic             clr_c;
  logic             norm_en_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN lasts two cycles, tracked by drain_q
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (src_rdy && (cnt_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    rd_en_c   = 1'b0;
    clr_c     = 1'b0;
    norm_en_c = 1'b0;
    cnt_d     = cnt_q;
    drain_d   = 1'b0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr_c = 1'b1;
          cnt_d = '0;
        end
      end
      RUN: begin
        // Stall holds the index; the final increment wraps to 0 and is never reused
        if (src_rdy) begin
          rd_en_c = 1'b1;
          cnt_d   = cnt_q + LOG2N'(1);
        end
      end
      DRAIN:   drain_d   = ~drain_q;
      NORM:    norm_en_c = 1'b1;
      default: ;
    endcase
  end

  // Counter, enable delay pipe and handshake registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      mult_en_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      mult_en_q <= rd_en_c;
      acc_en_q  <= mult_en_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  cov_accum #(
    .DW    (DW),
    .LOG2N (LOG2N),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .acc_en  (acc_en_q),
    .norm_en (norm_en_c),
    .prod_in (prod_in),
    .cov_out (cov_out)
  );

  // rd_en must respond to src_rdy in the same cycle
  assign rd_en   = rd_en_c;
  assign rd_addr = cnt_q;
  assign mult_en = mult_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cov_seq_ctrl.sv
// Self-checking bench for cov_seq_ctrl: directed frames with random data and
// stall patterns, compared against a sum/floor-divide reference model.
module tb_cov_seq_ctrl;

  localparam int unsigned LOG2N = 7;
  localparam int unsigned DW    = 16;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned NP    = 10;
  localparam int unsigned VW    = NP * DW;
  localparam int          NS    = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          src_rdy;
  logic          rd_en;
  logic [LOG2N-1:0] rd_addr;
  logic          mult_en;
  logic [VW-1:0] prod_in;
  logic [VW-1:0] cov_out;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  int            vec [NS][NP];
  logic [VW-1:0] exp_cov;
  logic [VW-1:0] p_next, p_next2;
  bit            v_next, v_next2;

  always #5 clk = ~clk;

  cov_seq_ctrl #(
    .N_SAMPLES (128),
    .LOG2N     (LOG2N),
    .DW        (DW),
    .ACC_W     (ACC_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .src_rdy (src_rdy),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .mult_en (mult_en),
    .prod_in (prod_in),
    .cov_out (cov_out),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < int'(NP); i++) r[DW*i +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [VW-1:0] pack(input int a);
    logic [VW-1:0] r;
    for (int i = 0; i < int'(NP); i++) r[DW*i +: DW] = DW'(vec[a][i]);
    return r;
  endfunction

  // Mean of the frame's products for one lane, floor (or round half up) division
  function automatic int lane_mean(input int lane);
    int s, q;
    s = 0;
    for (int k = 0; k < NS; k++) s += vec[k][lane];
`ifdef COV_ROUND_EN
    s = s + NS / 2;
`endif
    q = s / NS;
    if ((s % NS) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [VW-1:0] model_cov();
    logic [VW-1:0] r;
    for (int i = 0; i < int'(NP); i++) r[DW*i +: DW] = DW'(lane_mean(i));
    return r;
  endfunction

  task automatic fill_const(input int v0, input int vrest);
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < int'(NP); i++) vec[k][i] = (i == 0) ? v0 : vrest;
  endtask

  task automatic fill_rand();
    logic [DW-1:0] r;
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < int'(NP); i++) begin
        r = DW'($urandom);
        vec[k][i] = int'(signed'(r));
      end
  endtask

  // stall_kind: 0 always ready, 1 ready on odd cycles, 2 random ~75%
  task automatic run_frame(input int stall_kind, input int xs_a, input int xs_b, input int rst_cyc);
    int reads, last_read;
    bit prev_rd, exp_rd, fin, exp_busy, exp_done;
    reads = 0; last_read = -1; prev_rd = 1'b0; fin = 1'b0;
    v_next = 1'b0; v_next2 = 1'b0;
    @(posedge clk); #1;
    start   = 1'b1;
    src_rdy = 1'($urandom);
    prod_in = rand_vec();
    @(negedge clk);
    chk("idle_busy", VW'(busy), VW'(0));
    for (int cyc = 1; cyc < 1000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == xs_a || cyc == xs_b);
      rst_n = (cyc != rst_cyc);
      case (stall_kind)
        0:       src_rdy = 1'b1;
        1:       src_rdy = ((cyc % 2) == 1);
        default: src_rdy = ($urandom_range(0, 3) != 0);
      endcase
      prod_in = v_next ? p_next : rand_vec();
      v_next  = v_next2;
      p_next  = p_next2;
      v_next2 = 1'b0;
      @(negedge clk);
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        chk("rst_busy",    VW'(busy),    VW'(0));
        chk("rst_rd_en",   VW'(rd_en),   VW'(0));
        chk("rst_mult_en", VW'(mult_en), VW'(0));
        chk("rst_done",    VW'(done),    VW'(0));
        exp_cov = '0;
        chk("rst_cov", cov_out, exp_cov);
        fin = 1'b1;
      end else if (cyc != rst_cyc) begin
        exp_rd   = (reads < NS) && src_rdy;
        exp_busy = (reads < NS) || (cyc <= last_read + 4);
        exp_done = (last_read >= 0) && (cyc == last_read + 4);
        chk("rd_en",   VW'(rd_en),   VW'(exp_rd));
        chk("mult_en", VW'(mult_en), VW'(prev_rd));
        chk("busy",    VW'(busy),    VW'(exp_busy));
        chk("done",    VW'(done),    VW'(exp_done));
        if (exp_rd) chk("rd_addr", VW'(rd_addr), VW'(reads));
        if (exp_done) exp_cov = model_cov();
        chk("cov", cov_out, exp_cov);
        prev_rd = exp_rd;
        if (exp_rd) begin
          p_next2 = pack(reads);
          v_next2 = 1'b1;
          reads++;
          if (reads == NS) last_read = cyc;
        end
        if (last_read >= 0 && cyc == last_read + 5) fin = 1'b1;
      end
    end
    chk("frame_end", VW'(fin), VW'(1));
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    src_rdy = 1'b0;
    prod_in = '0;
    exp_cov = '0;
    p_next  = '0;
    p_next2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",    VW'(busy),    VW'(0));
    chk("reset_done",    VW'(done),    VW'(0));
    chk("reset_rd_en",   VW'(rd_en),   VW'(0));
    chk("reset_mult_en", VW'(mult_en), VW'(0));
    chk("reset_rd_addr", VW'(rd_addr), VW'(0));
    chk("reset_cov",     cov_out,      VW'(0));
    rst_n = 1'b1;

    // All lanes +1, no stalls
    fill_const(1, 1);
    run_frame(0, -1, -1, -1);

    // Lane0 constant -3
    fill_const(-3, 0);
    run_frame(0, -1, -1, -1);

    // Lane0 alternating +1/-2, sum -64
    fill_const(0, 0);
    for (int k = 0; k < NS; k++) vec[k][0] = ((k % 2) == 0) ? 1 : -2;
    run_frame(0, -1, -1, -1);

    // Lane9 sum 191 then 192
    fill_const(0, 0);
    for (int k = 0; k < NS; k++) vec[k][9] = 1;
    vec[NS-1][9] = 64;
    run_frame(0, -1, -1, -1);
    vec[NS-1][9] = 65;
    run_frame(0, -1, -1, -1);

    // Ready every other cycle
    fill_const(1, 1);
    run_frame(1, -1, -1, -1);

    // Extra start pulses while busy and in DONE are ignored
    fill_rand();
    run_frame(0, 50, 132, -1);
    fill_rand();
    run_frame(2, -1, -1, -1);

    // Reset mid-frame, then a fresh frame
    fill_rand();
    run_frame(0, -1, -1, 60);
    fill_rand();
    run_frame(2, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
